// File: rtl/delay_scheduler.sv
// Shared down-counting delay timer, granted to up to three requesters by fixed priority.
// Optional build macro DELAY_SCHEDULER_PREEMPT_EN lets a higher-priority pending request preempt the owner.
module delay_scheduler #(
    parameter int CNT_W = 18,
    parameter int N_REQ = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic [N_REQ-1:0] CANCEL,
    input  logic [CNT_W-1:0] DLY0,
    input  logic [CNT_W-1:0] DLY1,
    input  logic [CNT_W-1:0] DLY2,
    output logic [N_REQ-1:0] DONE,
    output logic             BUSY,
    output logic [1:0]       ACTIVE_ID,
    output logic [N_REQ-1:0] PENDING,
    output logic [CNT_W-1:0] REMAIN
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [N_REQ-1:0] pending_r, pending_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [1:0]       id_r, id_nxt_s;
    logic [N_REQ-1:0] done_r, done_nxt_s;
    logic [N_REQ-1:0] eligible_s;
    logic [N_REQ-1:0] act_mask_s;
    logic [N_REQ-1:0] higher_s;
    logic [1:0]       grant_id_s;

    function automatic logic [1:0] lowest_idx(input logic [N_REQ-1:0] v);
        lowest_idx = 2'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = 2'(i);
        end
    endfunction

    function automatic logic [N_REQ-1:0] id_mask(input logic [1:0] id);
        id_mask = N_REQ'(1'b1) << id;
    endfunction

    // A programmed delay of zero still costs one tick
    function automatic logic [CNT_W-1:0] load_val(input logic [1:0] id,
                                                  input logic [CNT_W-1:0] d0,
                                                  input logic [CNT_W-1:0] d1,
                                                  input logic [CNT_W-1:0] d2);
        logic [CNT_W-1:0] d;
        case (id)
            2'd0:    d = d0;
            2'd1:    d = d1;
            default: d = d2;
        endcase
        load_val = (d == '0) ? CNT_W'(1'b1) : d;
    endfunction

    // Next-state, pending queue, counter and expiry pulse
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        cnt_nxt_s     = cnt_r;
        id_nxt_s      = id_r;
        done_nxt_s    = '0;
        eligible_s    = pending_r & ~CANCEL;
        grant_id_s    = lowest_idx(eligible_s);
        act_mask_s    = id_mask(id_r);
        higher_s      = eligible_s & (act_mask_s - N_REQ'(1'b1));
        case (state_r)
            ST_IDLE: begin
                pending_nxt_s = (pending_r | REQ) & ~CANCEL;
                if (eligible_s != '0) begin
                    state_nxt_s   = ST_COUNT;
                    id_nxt_s      = grant_id_s;
                    cnt_nxt_s     = load_val(grant_id_s, DLY0, DLY1, DLY2);
                    pending_nxt_s = pending_nxt_s & ~id_mask(grant_id_s);
                end else begin
                    cnt_nxt_s = '0;
                end
            end
            ST_COUNT: begin
                // A REQ from the owner is a retrigger, never a new queue entry
                pending_nxt_s = (pending_r | (REQ & ~act_mask_s)) & ~CANCEL;
                if ((CANCEL & act_mask_s) != '0) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else if ((REQ & act_mask_s) != '0) begin
                    cnt_nxt_s = load_val(id_r, DLY0, DLY1, DLY2);
                end else if (cnt_r <= CNT_W'(1'b1)) begin
                    done_nxt_s  = act_mask_s;
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
`ifdef DELAY_SCHEDULER_PREEMPT_EN
                // Expiry takes precedence; otherwise the owner is requeued with a full delay
                end else if (higher_s != '0) begin
                    id_nxt_s      = grant_id_s;
                    cnt_nxt_s     = load_val(grant_id_s, DLY0, DLY1, DLY2);
                    pending_nxt_s = (pending_nxt_s | act_mask_s) & ~id_mask(grant_id_s);
`endif
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                pending_nxt_s = '0;
                cnt_nxt_s     = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            pending_r <= '0;
            cnt_r     <= '0;
            id_r      <= 2'd0;
            done_r    <= '0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            cnt_r     <= cnt_nxt_s;
            id_r      <= id_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign DONE      = done_r;
    assign BUSY      = (state_r == ST_COUNT);
    assign ACTIVE_ID = id_r;
    assign PENDING   = pending_r;
    assign REMAIN    = cnt_r;

endmodule

// File: tb/tb_delay_scheduler.sv
// Randomized bench for delay_scheduler against a cycle-level behavioural model of the scheduling rules.
module tb_delay_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  REQ = 3'b000;
    logic [2:0]  CANCEL = 3'b000;
    logic [17:0] DLY0 = 18'd0;
    logic [17:0] DLY1 = 18'd0;
    logic [17:0] DLY2 = 18'd0;
    logic [2:0]  DONE;
    logic        BUSY;
    logic [1:0]  ACTIVE_ID;
    logic [2:0]  PENDING;
    logic [17:0] REMAIN;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int       m_owner = -1;
    int       m_remain = 0;
    int       m_last_id = 0;
    bit [2:0] m_pend = 3'b000;
    bit [2:0] m_done = 3'b000;

    delay_scheduler #(.CNT_W(18), .N_REQ(3)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .CANCEL(CANCEL),
        .DLY0(DLY0), .DLY1(DLY1), .DLY2(DLY2),
        .DONE(DONE), .BUSY(BUSY), .ACTIVE_ID(ACTIVE_ID),
        .PENDING(PENDING), .REMAIN(REMAIN)
    );

    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int dly_of(input int i);
        int d;
        d = (i == 0) ? int'(DLY0) : (i == 1) ? int'(DLY1) : int'(DLY2);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int lowest(input bit [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input bit [2:0] req, input bit [2:0] can, input bit rst);
        bit [2:0] np;
        int g;
        m_done = 3'b000;
        if (rst) begin
            m_owner = -1; m_remain = 0; m_last_id = 0; m_pend = 3'b000;
        end else if (m_owner < 0) begin
            np = (m_pend | req) & ~can;
            g = lowest(m_pend & ~can);
            if (g >= 0) begin
                m_owner = g; m_last_id = g; m_remain = dly_of(g); np[g] = 1'b0;
            end
            m_pend = np;
        end else begin
            np = m_pend | req;
            np[m_owner] = m_pend[m_owner];
            np = np & ~can;
            g = lowest(m_pend & ~can);
            if (can[m_owner]) begin
                m_owner = -1; m_remain = 0;
            end else if (req[m_owner]) begin
                m_remain = dly_of(m_owner);
            end else if (m_remain <= 1) begin
                m_done[m_owner] = 1'b1; m_owner = -1; m_remain = 0;
`ifdef DELAY_SCHEDULER_PREEMPT_EN
            end else if (g >= 0 && g < m_owner) begin
                np[m_owner] = 1'b1; np[g] = 1'b0;
                m_owner = g; m_last_id = g; m_remain = dly_of(g);
`endif
            end else begin
                m_remain = m_remain - 1;
            end
            m_pend = np;
        end
    endtask

    task automatic run_cycle(input logic [2:0] req, input logic [2:0] can, input logic rst);
        @(negedge CLK);
        REQ = req; CANCEL = can; RST = rst;
        @(posedge CLK);
        model_step(req, can, rst);
        #1;
        check_value("done", DONE, m_done);
        check_value("busy", BUSY, (m_owner >= 0));
        check_value("active_id", ACTIVE_ID, m_last_id);
        check_value("pending", PENDING, m_pend);
        check_value("remain", REMAIN, m_remain);
    endtask

    initial begin
        run_cycle(3'b000, 3'b000, 1'b1);
        run_cycle(3'b000, 3'b000, 1'b1);
        check_value("rst_busy", BUSY, 1'b0);
        check_value("rst_remain", REMAIN, 18'd0);
        check_value("rst_pending", PENDING, 3'b000);

        // Single request with delay 5
        DLY1 = 18'd5;
        run_cycle(3'b010, 3'b000, 1'b0);
        check_value("t1_pend", PENDING, 3'b010);
        run_cycle(3'b000, 3'b000, 1'b0);
        check_value("t1_grant_id", ACTIVE_ID, 2'd1);
        check_value("t1_grant_remain", REMAIN, 18'd5);
        for (int i = 1; i <= 4; i++) begin
            run_cycle(3'b000, 3'b000, 1'b0);
            check_value("t1_count", REMAIN, 18'(5 - i));
        end
        run_cycle(3'b000, 3'b000, 1'b0);
        check_value("t1_done", DONE, 3'b010);
        check_value("t1_idle", BUSY, 1'b0);

        // Simultaneous requests served in index order
        DLY0 = 18'd3; DLY2 = 18'd4;
        run_cycle(3'b101, 3'b000, 1'b0);
        check_value("t2_pend", PENDING, 3'b101);
        for (int i = 0; i < 4; i++) run_cycle(3'b000, 3'b000, 1'b0);
        check_value("t2_done0", DONE, 3'b001);
        run_cycle(3'b000, 3'b000, 1'b0);
        check_value("t2_grant2", ACTIVE_ID, 2'd2);
        check_value("t2_remain2", REMAIN, 18'd4);
        for (int i = 0; i < 4; i++) run_cycle(3'b000, 3'b000, 1'b0);
        check_value("t2_done2", DONE, 3'b100);

        // Cancel and request together on an idle index
        run_cycle(3'b010, 3'b010, 1'b0);
        check_value("t3_cancel_wins", PENDING, 3'b000);

        // Zero delay expires one edge after grant
        DLY2 = 18'd0;
        run_cycle(3'b100, 3'b000, 1'b0);
        run_cycle(3'b000, 3'b000, 1'b0);
        run_cycle(3'b000, 3'b000, 1'b0);
        check_value("t5_zero_dly", DONE, 3'b100);

        // Randomized traffic: sparse requests, rarer cancels and resets, changing delays
        for (int c = 0; c < 4000; c++) begin
            logic [2:0] r, k;
            logic       s;
            r = 3'b000; k = 3'b000;
            for (int b = 0; b < 3; b++) begin
                r[b] = ($urandom_range(0, 7) == 0);
                k[b] = ($urandom_range(0, 39) == 0);
            end
            s = ($urandom_range(0, 599) == 0);
            DLY0 = 18'($urandom_range(0, 6));
            DLY1 = 18'($urandom_range(0, 9));
            DLY2 = 18'($urandom_range(0, 12));
            run_cycle(r, k, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
